dm_store_rmw: RTL and testbench

- Store-path counterpart of the load extension logic in the MEM stage.
- Takes SW/SH/SB requests and places byte/halfword data on the correct little-endian lanes.
- The data memory is word-wide, has no byte write enables and has a synchronous read. Partial stores are therefore done as a 2-cycle read-modify-write, and the block stalls the pipeline for one cycle while it runs.
- Flags misaligned stores and suppresses them.

---
 rtl/dm_store_rmw.sv | 184 ++++++++++++++++++
 tb/tb_dm_store_rmw.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_store_rmw.sv
// dm_store_rmw: MEM-stage store path.
// Places SW/SH/SB data on little-endian byte lanes of a word-wide data memory.
// The default build targets a memory without byte enables, so partial stores
// run as a read (IDLE, stall=1) followed by a merged write (MERGE).
// Optional build macro DM_STORE_BYTE_WE_EN: the memory honours mem_be, so
// partial stores become single-cycle writes and MERGE is never entered.
module dm_store_rmw #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_type,
  output logic              stall,
  output logic              misalign,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  output logic [CNT_W-1:0]  rmw_cnt
);

  localparam logic [1:0] T_SW = 2'b00;
  localparam logic [1:0] T_SB = 2'b01;
  localparam logic [1:0] T_SH = 2'b10;

  typedef enum logic {S_IDLE = 1'b0, S_MERGE = 1'b1} state_t;

  state_t            r_state;
  state_t            w_nstate;
  logic [ADDR_W+1:0] r_cap_addr;
  logic [15:0]       r_cap_data;
  logic [1:0]        r_cap_type;
  logic [CNT_W-1:0]  r_cnt;

  logic        w_is_sw;
  logic        w_is_sb;
  logic        w_is_sh;
  logic        w_mis;
  logic        w_sw_ok;
  logic        w_part;
  logic [31:0] w_merged;
  logic [3:0]  w_part_be;
  logic [31:0] w_part_rep;

  // Byte-address bits above the memory's word range are intentionally ignored.
  logic w_unused_addr;
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  // Request decode; reserved type 11 matches none of the three and is a no-op.
  assign w_is_sw = req_valid && (req_type == T_SW);
  assign w_is_sb = req_valid && (req_type == T_SB);
  assign w_is_sh = req_valid && (req_type == T_SH);
  assign w_mis   = (w_is_sw && (req_addr[1:0] != 2'b00)) ||
                   (w_is_sh && req_addr[0]);
  assign w_sw_ok = w_is_sw && !w_mis;
  assign w_part  = (w_is_sb || w_is_sh) && !w_mis;

  // Byte-enable / replicated data for partial stores when the memory has lanes.
  always_comb begin
    w_part_be  = 4'b0000;
    w_part_rep = 32'h0;
    if (w_is_sb) begin
      w_part_be  = 4'b0001 << req_addr[1:0];
      w_part_rep = {4{req_wdata[7:0]}};
    end else if (w_is_sh) begin
      w_part_be  = req_addr[1] ? 4'b1100 : 4'b0011;
      w_part_rep = {2{req_wdata[15:0]}};
    end
  end

  // Splice the captured byte/halfword into the word just read back.
  always_comb begin
    w_merged = mem_rdata;
    if (r_cap_type == T_SB) begin
      case (r_cap_addr[1:0])
        2'b00:   w_merged[7:0]   = r_cap_data[7:0];
        2'b01:   w_merged[15:8]  = r_cap_data[7:0];
        2'b10:   w_merged[23:16] = r_cap_data[7:0];
        default: w_merged[31:24] = r_cap_data[7:0];
      endcase
    end else if (r_cap_addr[1]) begin
      w_merged[31:16] = r_cap_data;
    end else begin
      w_merged[15:0]  = r_cap_data;
    end
  end

  // State register; reset abandons any pending merge.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nstate;
  end

  // Next-state: only a partial store without byte enables needs MERGE.
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE: begin
`ifdef DM_STORE_BYTE_WE_EN
        w_nstate = S_IDLE;
`else
        if (w_part) w_nstate = S_MERGE;
`endif
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // Capture the partial store while its read is in flight; contents are
  // don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_part) begin
      r_cap_addr <= req_addr[ADDR_W+1:0];
      r_cap_data <= req_wdata[15:0];
      r_cap_type <= req_type;
    end
  end

  // Saturating count of merged writes actually committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == S_MERGE && r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign rmw_cnt = r_cnt;

  // Outputs: combinational from state and request; reset forces the idle set.
  always_comb begin
    stall     = 1'b0;
    misalign  = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    mem_addr  = req_addr[ADDR_W+1:2];
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (w_mis) begin
            misalign = 1'b1;
          end else if (w_sw_ok) begin
            mem_we    = 1'b1;
            mem_be    = 4'b1111;
            mem_wdata = req_wdata;
            done      = 1'b1;
          end else if (w_part) begin
`ifdef DM_STORE_BYTE_WE_EN
            mem_we    = 1'b1;
            mem_be    = w_part_be;
            mem_wdata = w_part_rep;
            done      = 1'b1;
`else
            // mem_addr already points at the word; read returns next cycle.
            stall     = 1'b1;
`endif
          end
        end
        default: begin
          mem_addr  = r_cap_addr[ADDR_W+1:2];
          mem_we    = 1'b1;
          mem_be    = 4'b1111;
          mem_wdata = w_merged;
          done      = 1'b1;
        end
      endcase
    end
  end

`ifndef DM_STORE_BYTE_WE_EN
  // Lane data is only consumed when the memory has byte enables.
  logic w_unused_part;
  assign w_unused_part = ^{w_part_be, w_part_rep};
`endif

endmodule

// File: tb/tb_dm_store_rmw.sv
// Scoreboarded bench for dm_store_rmw: directed stores push the expected
// memory write; a negedge monitor pops and checks every write the DUT issues.
module tb_dm_store_rmw;
  localparam int AW = 4;
  localparam int CW = 2;
  localparam logic [1:0] T_SW = 2'b00;
  localparam logic [1:0] T_SB = 2'b01;
  localparam logic [1:0] T_SH = 2'b10;
  localparam logic [1:0] T_RV = 2'b11;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [1:0]    req_type;
  logic          stall;
  logic          misalign;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [CW-1:0] rmw_cnt;

  logic [31:0] mem [2**AW];
  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;

  dm_store_rmw #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_type(req_type), .stall(stall),
    .misalign(misalign), .done(done), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .rmw_cnt(rmw_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory with synchronous read; byte enables honoured per lane.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Monitor: every issued write must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {mem_be, 24'h0, 4'(mem_addr)}, 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", mem_wdata, e.data);
        chk("wr_be",   32'(mem_be),   32'(e.be));
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_type = t;
  endtask

  task automatic idle_req();
    req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_type = T_SW;
  endtask

  // Aligned SW: single-cycle write.
  task automatic do_sw(input logic [31:0] a, input logic [31:0] d);
    sb_q.push_back('{addr: a[AW+1:2], data: d, be: 4'hF});
    drive(a, d, T_SW);
    @(negedge clk);
    chk("sw_addr", 32'(mem_addr), 32'(a[AW+1:2]));
    chk("sw_stall", 32'(stall), 32'd0);
    chk("sw_done",  32'(done),  32'd1);
    @(posedge clk); #1 idle_req();
  endtask

  // Partial store; merged = final word, fbe/frep = byte-enable-mode write.
  task automatic do_part(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t,
                         input logic [31:0] merged, input logic [3:0] fbe,
                         input logic [31:0] frep, input logic [1:0] cnt);
`ifdef DM_STORE_BYTE_WE_EN
    sb_q.push_back('{addr: a[AW+1:2], data: frep, be: fbe});
    drive(a, d, t);
    @(negedge clk);
    chk("p_stall", 32'(stall), 32'd0);
    chk("p_done",  32'(done),  32'd1);
    @(posedge clk); #1 idle_req();
    chk("p_cnt", 32'(rmw_cnt), 32'd0);
`else
    sb_q.push_back('{addr: a[AW+1:2], data: merged, be: 4'hF});
    drive(a, d, t);
    @(negedge clk);
    chk("p_rd_stall", 32'(stall),  32'd1);
    chk("p_rd_we",    32'(mem_we), 32'd0);
    chk("p_rd_done",  32'(done),   32'd0);
    @(posedge clk); #1 idle_req();
    @(negedge clk);
    chk("p_wr_stall", 32'(stall), 32'd0);
    chk("p_wr_done",  32'(done),  32'd1);
    @(posedge clk); #1;
    chk("p_cnt", 32'(rmw_cnt), 32'(cnt));
`endif
    chk("p_mem", mem[a[AW+1:2]], merged);
  endtask

  // Dropped request: misaligned, or reserved type.
  task automatic do_drop(input logic [31:0] a, input logic [1:0] t, input logic exp_mis);
    drive(a, 32'hFFFF_FFFF, t);
    @(negedge clk);
    chk("drop_mis",   32'(misalign), 32'(exp_mis));
    chk("drop_stall", 32'(stall),    32'd0);
    chk("drop_done",  32'(done),     32'd0);
    @(posedge clk); #1 idle_req();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 32'h0;
    mem[0] = 32'h0102_0304;
    mem[1] = 32'hA0A1_A2A3;
    reset = 1'b1;
    drive(32'h24, 32'h5555_5555, T_SW);
    @(posedge clk); @(negedge clk);
    chk("rst_we",    32'(mem_we),   32'd0);
    chk("rst_stall", 32'(stall),    32'd0);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_be",    32'(mem_be),   32'd0);
    chk("rst_wdata", mem_wdata,     32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd9);
    chk("rst_cnt",   32'(rmw_cnt),  32'd0);
    @(posedge clk); #1 reset = 1'b0; idle_req();

    do_sw(32'h8, 32'hDEAD_BEEF);
    chk("sw_mem", mem[2], 32'hDEAD_BEEF);

    mem[2] = 32'h1122_3344;
    do_part(32'hA, 32'hAB, T_SB, 32'h11AB_3344, 4'b0100, 32'hABAB_ABAB, 2'd1);
    mem[2] = 32'h1122_3344;
    do_part(32'hA, 32'hCAFE, T_SH, 32'hCAFE_3344, 4'b1100, 32'hCAFE_CAFE, 2'd2);
    do_part(32'h8, 32'hBEEF, T_SH, 32'hCAFE_BEEF, 4'b0011, 32'hBEEF_BEEF, 2'd3);

    do_drop(32'h6, T_SW, 1'b1);
    do_drop(32'h3, T_SH, 1'b1);
    do_drop(32'h4, T_RV, 1'b0);
    chk("mis_mem0", mem[0], 32'h0102_0304);
    chk("mis_mem1", mem[1], 32'hA0A1_A2A3);

    do_part(32'h5, 32'h7F, T_SB, 32'hA0A1_7FA3, 4'b0010, 32'h7F7F_7F7F, 2'd3);

`ifndef DM_STORE_BYTE_WE_EN
    // Reset lands on the MERGE cycle: no write, counter cleared.
    drive(32'hC, 32'h99, T_SB);
    @(negedge clk);
    chk("rm_stall", 32'(stall), 32'd1);
    @(posedge clk); #1 reset = 1'b1; idle_req();
    @(negedge clk);
    chk("rm_we",   32'(mem_we), 32'd0);
    chk("rm_done", 32'(done),   32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rm_idle_we", 32'(mem_we),  32'd0);
    chk("rm_cnt",     32'(rmw_cnt), 32'd0);
    chk("rm_mem",     mem[3],       32'h0);
    @(posedge clk); #1;
`endif

    // Back-to-back byte stores to one word; counter saturates at 3.
    do_part(32'h10, 32'h11, T_SB, 32'h0000_0011, 4'b0001, 32'h1111_1111, 2'd1);
    do_part(32'h11, 32'h22, T_SB, 32'h0000_2211, 4'b0010, 32'h2222_2222, 2'd2);
    do_part(32'h12, 32'h33, T_SB, 32'h0033_2211, 4'b0100, 32'h3333_3333, 2'd3);
    do_part(32'h13, 32'h44, T_SB, 32'h4433_2211, 4'b1000, 32'h4444_4444, 2'd3);
    do_part(32'h10, 32'h55, T_SB, 32'h4433_2255, 4'b0001, 32'h5555_5555, 2'd3);

    repeat (2) @(posedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
